// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the sequential multiply/divide unit: RV32M funct3
// operation codes (also used by the control-unit decoder) and FSM states.
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // Divide/remainder ops share funct3[2].
    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // rs1 is interpreted as signed for these ops.
    function automatic logic op_a_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is interpreted as signed for these ops.
    function automatic logic op_b_signed(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit. Operands are reduced to magnitudes
// at accept, one radix-2 step runs per cycle (shift-add multiply, restoring
// divide), and the sign is restored on the last step. Divide-by-zero and
// signed overflow finish one cycle after accept.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [XLEN-1:0]  req_a,
    input  logic [XLEN-1:0]  req_b,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [XLEN-1:0]  resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             busy
);
    import muldiv_seq_pkg::*;

    localparam int              CW        = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic [2*XLEN-1:0] acc_q, acc_d;       // {hi/remainder, lo/multiplier-quotient}
    logic [XLEN-1:0]   b_mag_q, b_mag_d;   // multiplicand or divisor magnitude
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              res_neg_q, res_neg_d; // product / quotient is negative
    logic              rem_neg_q, rem_neg_d; // remainder (dividend) is negative
    logic              div_zero_q, div_zero_d;
    logic              ovf_q, ovf_d;

    // Accept-side operand conditioning.
    muldiv_op_e      op_in;
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in;

    assign op_in    = muldiv_op_e'(req_op);
    assign a_neg_in = op_a_signed(op_in) && req_a[XLEN-1];
    assign b_neg_in = op_b_signed(op_in) && req_b[XLEN-1];
    assign a_mag_in = a_neg_in ? -req_a : req_a;
    assign b_mag_in = b_neg_in ? -req_b : req_b;

    // One iteration of each algorithm, plus sign-corrected results.
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, iter_next, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, a_orig, final_res, special_res;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_mag_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, b_mag_q};
    assign div_next  = div_diff[XLEN]
                     ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                     : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    assign iter_next = op_is_div(op_q) ? div_next : mul_next;

    assign prod_fix  = res_neg_q ? -iter_next : iter_next;
    assign quo_fix   = res_neg_q ? -iter_next[XLEN-1:0] : iter_next[XLEN-1:0];
    assign rem_fix   = rem_neg_q ? -iter_next[2*XLEN-1:XLEN] : iter_next[2*XLEN-1:XLEN];
    // Before any iteration the low half still holds |a|; re-sign it to get a back.
    assign a_orig    = rem_neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];

    // Result selection by operation, for the normal and the early-exit paths.
    always_comb begin
        unique case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo_fix;
            default:                      final_res = rem_fix;
        endcase
        if (op_q inside {OP_DIV, OP_DIVU})
            special_res = div_zero_q ? '1 : acc_q[XLEN-1:0];
        else
            special_res = div_zero_q ? a_orig : '0;
    end

    assign req_ready  = (state_q == ST_IDLE) && !flush;
    assign resp_valid = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

    // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        tag_d       = tag_q;
        resp_tag_d  = resp_tag_q;
        resp_data_d = resp_data_q;
        acc_d       = acc_q;
        b_mag_d     = b_mag_q;
        cnt_d       = cnt_q;
        res_neg_d   = res_neg_q;
        rem_neg_d   = rem_neg_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_d       = op_in;
                    tag_d      = req_tag;
                    acc_d      = {{XLEN{1'b0}}, a_mag_in};
                    b_mag_d    = b_mag_in;
                    cnt_d      = '0;
                    res_neg_d  = a_neg_in ^ b_neg_in;
                    rem_neg_d  = a_neg_in;
                    div_zero_d = op_is_div(op_in) && (req_b == '0);
                    ovf_d      = op_is_div(op_in) && op_a_signed(op_in)
                                 && (req_a == INT_MIN) && (&req_b);
                    state_d    = ST_CALC;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_zero_q || ovf_q) begin
                    resp_data_d = special_res;
                    resp_tag_d  = tag_q;
                    state_d     = ST_DONE;
                end else begin
                    acc_d = iter_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        resp_data_d = final_res;
                        resp_tag_d  = tag_q;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (flush || resp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so an aborted operation leaves no stale value behind.
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            tag_q       <= '0;
            resp_tag_q  <= '0;
            resp_data_q <= '0;
            acc_q       <= '0;
            b_mag_q     <= '0;
            cnt_q       <= '0;
            res_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            resp_tag_q  <= resp_tag_d;
            resp_data_q <= resp_data_d;
            acc_q       <= acc_d;
            b_mag_q     <= b_mag_d;
            cnt_q       <= cnt_d;
            res_neg_q   <= res_neg_d;
            rem_neg_q   <= rem_neg_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq at XLEN=32: arithmetic results, latencies,
// early-exit cases, response hold, flush and asynchronous reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [4:0]  req_tag;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_tag;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_seq #(.XLEN(32), .TAG_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_tag    (req_tag),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request at a negedge; returns 1 ns after the accept edge.
    task automatic send(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        check({name, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check({name, " busy"}, 64'(busy), 64'd1);
    endtask

    // resp_valid must be low one cycle before the latency and high at it.
    task automatic wait_resp(input string name, input int lat, input logic [31:0] exp,
                             input logic [4:0] tag);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        check({name, " early valid"}, 64'(resp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({name, " valid"}, 64'(resp_valid), 64'd1);
        check({name, " data"}, 64'(resp_data), 64'(exp));
        check({name, " tag"}, 64'(resp_tag), 64'(tag));
    endtask

    // Called at a negedge with resp_valid high.
    task automatic take_resp(input string name);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({name, " valid after take"}, 64'(resp_valid), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input int lat,
                          input logic [31:0] exp);
        send(name, op, a, b, tag);
        wait_resp(name, lat, exp, tag);
        take_resp(name);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = 32'd0;
        req_b      = 32'd0;
        req_tag    = 5'd0;
        flush      = 1'b0;
        resp_ready = 1'b0;

        #2;
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset resp_data", 64'(resp_data), 64'd0);
        check("reset resp_tag", 64'(resp_tag), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Divide with mixed signs and full latency.
        run_op("DIV 7/-2",  OP_DIV,  32'd7, 32'hFFFF_FFFE, 5'd1, 32, 32'hFFFF_FFFD);
        run_op("REM 7/-2",  OP_REM,  32'd7, 32'hFFFF_FFFE, 5'd2, 32, 32'h0000_0001);
        run_op("DIV -7/2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd3, 32, 32'hFFFF_FFFD);
        run_op("REM -7/2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd4, 32, 32'hFFFF_FFFF);
        run_op("DIVU big",  OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd5, 32, 32'h0FFF_FFFF);

        // Multiplies.
        run_op("MULH min*min", OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6, 32, 32'h4000_0000);
        run_op("MULHU max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32, 32'hFFFF_FFFE);
        run_op("MUL max",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32, 32'h0000_0001);
        run_op("MULHSU -1*2",  OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd9, 32, 32'hFFFF_FFFF);
        run_op("MUL 1234*567", OP_MUL,    32'd1234,      32'd567,      5'd10, 32, 32'd699678);

        // Early exits one cycle after accept.
        run_op("DIVU 5/0",  OP_DIVU, 32'd5, 32'd0, 5'd11, 1, 32'hFFFF_FFFF);
        run_op("REMU 5/0",  OP_REMU, 32'd5, 32'd0, 5'd12, 1, 32'h0000_0005);
        run_op("REM -5/0",  OP_REM,  32'hFFFF_FFFB, 32'd0, 5'd13, 1, 32'hFFFF_FFFB);
        run_op("DIV ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1, 32'h8000_0000);
        run_op("REM ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1, 32'h0000_0000);

        // Response held while the consumer stalls.
        send("hold", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'h1A);
        wait_resp("hold", 32, 32'hFFFF_FFFD, 5'h1A);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold valid", 64'(resp_valid), 64'd1);
            check("hold data", 64'(resp_data), 64'hFFFF_FFFD);
            check("hold tag", 64'(resp_tag), 64'h1A);
            check("hold req_ready", 64'(req_ready), 64'd0);
        end
        take_resp("hold");

        // Flush during the fifth CALC cycle.
        send("flush calc", OP_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        check("flush calc busy before", 64'(busy), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush calc busy after", 64'(busy), 64'd0);
        check("flush calc valid", 64'(resp_valid), 64'd0);
        repeat (35) @(posedge clk);
        @(negedge clk);
        check("flush calc no late valid", 64'(resp_valid), 64'd0);
        check("flush calc data kept", 64'(resp_data), 64'hFFFF_FFFD);

        // Flush beats a request in IDLE.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_DIVU;
        req_a     = 32'd9;
        req_b     = 32'd3;
        flush     = 1'b1;
        #1 check("flush idle req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush idle busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-CALC.
        send("rst calc", OP_DIVU, 32'd100, 32'd7, 5'd5);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst resp_data", 64'(resp_data), 64'd0);
        check("rst resp_tag", 64'(resp_tag), 64'd0);
        #8 rst = 1'b0;
        @(negedge clk);
        check("post rst req_ready", 64'(req_ready), 64'd1);
        check("post rst busy", 64'(busy), 64'd0);
        run_op("DIVU 100/7 a", OP_DIVU, 32'd100, 32'd7, 5'd1, 32, 32'd14);
        run_op("DIVU 100/7 b", OP_DIVU, 32'd100, 32'd7, 5'd2, 32, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (any even value from 8 to 64).
REQ-002 SHALL have parameter TAG_W, default 5, width of the destination-register tag carried with each operation.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1, request present.
REQ-006 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-007 SHALL have port req_op, input, 3, RV32M funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports req_a and req_b, input, XLEN each, rs1 and rs2 operands.
REQ-009 SHALL have port req_tag, input, TAG_W, destination register address.
REQ-010 SHALL have port flush, input, 1, abort the in-flight operation (jump/interrupt).
REQ-011 SHALL have port resp_valid, output, 1, result available.
REQ-012 SHALL have port resp_ready, input, 1, consumer takes the result.
REQ-013 SHALL have port resp_data, output, XLEN, result.
REQ-014 SHALL have port resp_tag, output, TAG_W, tag of the result.
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE; drives the pipeline hold.

Function
REQ-016 SHALL implement FSM states IDLE, CALC and DONE.
REQ-017 SHALL set req_ready = (state == IDLE) && !flush, combinationally.
REQ-018 SHALL treat the edge with req_valid && req_ready high as the accept edge; at it, register op, tag, operand magnitudes and result signs, clear the iteration counter, and move to CALC.
REQ-019 SHALL perform one radix-2 iteration per cycle in CALC: shift-add for multiply (2*XLEN-bit accumulator), restoring shift-subtract for divide; counter width is clog2(XLEN)+1.
REQ-020 SHALL, on the XLEN-th CALC edge, apply sign correction, register resp_data and move to DONE, so that resp_valid is high XLEN cycles after the accept edge.
REQ-021 SHALL select the result as follows: MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
REQ-022 SHALL handle DIV/REM signs as follows: quotient is negative iff operand signs differ; remainder takes the dividend's sign.
REQ-023 SHALL handle divide-by-zero by going to DONE on the edge after accept: quotient all-ones, remainder = req_a.
REQ-024 SHALL handle signed overflow (DIV/REM with a = -2^(XLEN-1), b = -1) by going to DONE on the edge after accept: quotient = req_a, remainder 0.
REQ-025 SHALL drive resp_valid = (state == DONE); resp_data and resp_tag stay stable while resp_valid is high and resp_ready is low.
REQ-026 SHALL, in DONE with resp_ready high, return to IDLE on the next edge; a new request is accepted no earlier than the following cycle.
REQ-027 SHALL, when flush is high in CALC or DONE, return to IDLE on the next edge with no response produced; resp_valid falls after that edge.
REQ-028 SHALL give flush priority over a request in IDLE in the same cycle (request not accepted).
REQ-029 SHALL keep resp_data, resp_tag and internal datapath registers unchanged in IDLE (no toggling).

Reset
REQ-030 SHALL, while rst is high, immediately force state = IDLE, resp_valid = 0, busy = 0, resp_data = 0, resp_tag = 0, counter = 0, accumulators = 0, regardless of clock.
REQ-031 SHALL discard an operation in progress when reset asserts mid-operation; req_ready is 1 on the first cycle after rst deasserts.

Structure
REQ-032 SHALL take op encodings (shared with cu decode) and FSM state encodings from the shared defines file.
REQ-033 SHALL be a single module with no sub-module; a negate/abs helper stays inline.

Verification (XLEN=32)
REQ-034 SHALL cover: DIV a=7, b=-2 accepted at edge t -> resp_valid at t+32, resp_data=0xFFFFFFFD; REM same operands -> resp_data=1.
REQ-035 SHALL cover: MULH a=0x80000000, b=0x80000000 -> resp_data=0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MUL a=b=0xFFFFFFFF -> 0x00000001.
REQ-036 SHALL cover: DIVU a=5, b=0 -> resp_valid at t+1, resp_data=0xFFFFFFFF; REMU same operands -> resp_data=5; DIV a=0x80000000, b=-1 -> resp_data=0x80000000 at t+1.
REQ-037 SHALL cover: resp_ready held low 10 cycles in DONE with tag=0x1A -> resp_data and resp_tag=0x1A stable; req_ready=0 throughout.
REQ-038 SHALL cover: flush at CALC cycle 5 -> IDLE next edge, no resp_valid; req_valid with flush in IDLE -> not accepted.
REQ-039 SHALL cover: rst pulse mid-CALC, asynchronous to clk -> all outputs 0 immediately; after release, back-to-back DIVU 100/7 -> resp_data=14.
